lt_32b: RTL and testbench
=========================

Name: lt_32b

Overview:
- Unsigned 32-bit magnitude comparator for the Kolache ALU datapath; produces the SLT-style flag (a < b).
- Compare logic is combinational and the result is registered, so the ALU sees a clean, one-cycle-latency flag plus a valid strobe.
- Equality and greater-than are exposed as by-products for the branch/flag logic.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b are valid this cycle; sampled on the clk rising edge
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- Output  output  1  registered result, 1 when a < b (unsigned)
- eq  output  1  registered, 1 when a == b
- gt  output  1  registered, 1 when a > b (unsigned)
- out_valid  output  1  registered, 1 when Output/eq/gt hold a fresh result

Behaviour:
- Reset: while rst_n = 0, asynchronously Output = 0, eq = 0, gt = 0, out_valid = 0. Flops release on the first clk edge after rst_n rises.
- Comparison is unsigned. Bit WIDTH-1 is the MSB with no sign meaning; e.g. 0xFFFFFFFF is greater than 0x00000001.
- Compare core:
  - Split operands into WIDTH/4 nibbles; each nibble produces local lt_i/eq_i terms.
  - Combine nibbles from the MSB down: result lt = lt of the highest unequal nibble; eq = AND of all eq_i.
  - gt = NOT lt AND NOT eq.
  - The core uses no relational operator on the full vector. Exactly one of lt/eq/gt is 1 for any input.
- Latency: exactly 1 cycle. If in_valid = 1 at edge N, then after edge N:
  - Output/eq/gt reflect that cycle's a, b;
  - out_valid = 1.
- If in_valid = 0 at an edge, Output/eq/gt hold their previous values and out_valid = 0.
- Back-to-back: in_valid may be high every cycle; each edge produces an independent result, with no throughput bubble.
- Reset asserted mid-stream: any in-flight result is discarded and outputs go to their reset values immediately. The first result after reset needs a fresh in_valid.
- Boundary conditions:
  - a == b (all-zeros, all-ones, any value) -> Output = 0, eq = 1.
  - Operands differing only in the MSB or only in the LSB are resolved correctly.
  - X/Z on a/b while in_valid = 0 must not disturb held outputs.

Test Plan:
- Reset: drive rst_n = 0 asynchronously mid-cycle -> Output = 0, eq = 0, gt = 0, out_valid = 0 at once; hold in_valid = 1 with a = 1, b = 2 and release reset -> after the next edge Output = 1, out_valid = 1.
- Equal operands, in_valid = 1, consecutive cycles:
  - a = b = 0xFFFFFFFF -> Output = 0, eq = 1, gt = 0;
  - a = b = 0x00000000, 0x00000808, 0xFF98967F, 0x00000001 -> Output = 0, eq = 1 each cycle.
- Strict ordering:
  - a = 1, b = 2 -> Output = 1, eq = 0, gt = 0;
  - a = 9, b = 2 -> Output = 0, gt = 1;
  - a = 0xFF98967F, b = 0xFB98967F -> Output = 0, gt = 1 (unsigned; operands differ only at bit 26).
- Edge bits:
  - a = 0x7FFFFFFF, b = 0x80000000 -> Output = 1 (MSB decides, unsigned);
  - a = 0x80000000, b = 0x7FFFFFFF -> Output = 0, gt = 1;
  - a = 0x00000000, b = 0x00000001 -> Output = 1.
- Handshake: result for a = 1, b = 2, then in_valid = 0 for 3 cycles with a = 9, b = 2 on the bus -> Output stays 1, out_valid = 0 for those 3 cycles.
- Random: 10k random (a, b) pairs with in_valid toggling randomly, compared against a 1-cycle-delayed unsigned reference model -> zero mismatches; exactly one of Output/eq/gt high whenever out_valid = 1.

Source files
------------

// File: rtl/lt_32b.sv
// lt_32b - registered unsigned magnitude comparator.
//
// Compares two unsigned WIDTH-bit operands and registers the a < b flag
// together with the equality and greater-than by-products. Results appear
// one clock after in_valid is sampled high; when in_valid is low the flags
// hold and out_valid drops.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  a/b carry a valid operand pair this cycle
//   a, b      unsigned operands, WIDTH bits
//   Output    registered, 1 when a < b
//   eq        registered, 1 when a == b
//   gt        registered, 1 when a > b
//   out_valid registered, 1 when the flags hold a fresh result
//
// WIDTH must be a multiple of 4 and at least 4.

module lt_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             Output,
  output logic             eq,
  output logic             gt,
  output logic             out_valid
);

  localparam int NIB = WIDTH / 4;

  logic [NIB-1:0] nib_lt;
  logic [NIB-1:0] nib_eq;
  logic           lt_c;
  logic           eq_c;
  logic           gt_c;

  // Per-nibble local compare; only 4-bit relational operators are used.
  for (genvar i = 0; i < NIB; i++) begin : g_nib
    assign nib_lt[i] = (a[4*i +: 4] < b[4*i +: 4]);
    assign nib_eq[i] = (a[4*i +: 4] == b[4*i +: 4]);
  end

  // Walk from the most significant nibble down. While all higher nibbles are
  // equal, keep adopting the current nibble's result; the first unequal
  // nibble freezes lt and clears eq. If every nibble is equal, lt ends up 0.
  always_comb begin
    lt_c = 1'b0;
    eq_c = 1'b1;
    for (int i = NIB - 1; i >= 0; i--) begin
      if (eq_c) begin
        lt_c = nib_lt[i];
        eq_c = nib_eq[i];
      end
    end
    gt_c = ~lt_c & ~eq_c;
  end

  // Flags only load on a valid cycle, so X/Z on idle operands cannot reach them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Output    <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Output <= lt_c;
        eq     <= eq_c;
        gt     <= gt_c;
      end
    end
  end

endmodule

// File: tb/tb_lt_32b.sv
module tb_lt_32b;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_lt;
  logic        eq;
  logic        gt;
  logic        out_valid;

  int n_checks;
  int n_fail;

  lt_32b #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .Output    (out_lt),
    .eq        (eq),
    .gt        (gt),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and return 1 time unit after the rising edge.
  task automatic apply(input logic [31:0] va, input logic [31:0] vb, input logic v);
    a        = va;
    b        = vb;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_lt, eq, gt, out_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_initial: got %b want 0000", {out_lt, eq, gt, out_valid});
    end
    rst_n = 1'b1;
    apply(32'd9, 32'd2, 1'b1);
    n_checks++;
    if ({out_lt, eq, gt, out_valid} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_pre_result: got %b want 0011", {out_lt, eq, gt, out_valid});
    end
    // Assert reset mid-cycle; outputs must clear without a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_lt, eq, gt, out_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 0000", {out_lt, eq, gt, out_valid});
    end
    a        = 32'd1;
    b        = 32'd2;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({out_lt, eq, gt, out_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_no_edge: got %b want 0000", {out_lt, eq, gt, out_valid});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_lt, eq, gt, out_valid} !== 4'b1001) begin
      n_fail++;
      $display("FAIL reset_first_result: got %b want 1001", {out_lt, eq, gt, out_valid});
    end
  endtask

  task automatic test_equal();
    logic [31:0] vals [5];
    vals = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0808, 32'hFF98_967F, 32'h0000_0001};
    for (int i = 0; i < 5; i++) begin
      apply(vals[i], vals[i], 1'b1);
      n_checks++;
      if ({out_lt, eq, gt, out_valid} !== 4'b0101) begin
        n_fail++;
        $display("FAIL equal_%08h: got %b want 0101", vals[i], {out_lt, eq, gt, out_valid});
      end
    end
  endtask

  task automatic test_ordering();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [3:0]  ex [8];
    va = '{32'd1, 32'd9, 32'hFF98_967F, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000,
           32'hFFFF_FFFE, 32'h8000_0001};
    vb = '{32'd2, 32'd2, 32'hFB98_967F, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001,
           32'hFFFF_FFFF, 32'h8000_0000};
    ex = '{4'b1001, 4'b0011, 4'b0011, 4'b1001, 4'b0011, 4'b1001, 4'b1001, 4'b0011};
    for (int i = 0; i < 8; i++) begin
      apply(va[i], vb[i], 1'b1);
      n_checks++;
      if ({out_lt, eq, gt, out_valid} !== ex[i]) begin
        n_fail++;
        $display("FAIL order_%08h_%08h: got %b want %b", va[i], vb[i],
                 {out_lt, eq, gt, out_valid}, ex[i]);
      end
    end
  endtask

  task automatic test_handshake();
    apply(32'd1, 32'd2, 1'b1);
    n_checks++;
    if ({out_lt, eq, gt, out_valid} !== 4'b1001) begin
      n_fail++;
      $display("FAIL hs_load: got %b want 1001", {out_lt, eq, gt, out_valid});
    end
    for (int i = 0; i < 3; i++) begin
      apply(32'd9, 32'd2, 1'b0);
      n_checks++;
      if ({out_lt, eq, gt, out_valid} !== 4'b1000) begin
        n_fail++;
        $display("FAIL hs_hold_%0d: got %b want 1000", i, {out_lt, eq, gt, out_valid});
      end
    end
    apply('x, 'z, 1'b0);
    n_checks++;
    if ({out_lt, eq, gt, out_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL hs_hold_xz: got %b want 1000", {out_lt, eq, gt, out_valid});
    end
    apply(32'd9, 32'd2, 1'b1);
    n_checks++;
    if ({out_lt, eq, gt, out_valid} !== 4'b0011) begin
      n_fail++;
      $display("FAIL hs_resume: got %b want 0011", {out_lt, eq, gt, out_valid});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  exp_f;
    logic [31:0] va;
    logic [31:0] vb;
    logic        v;
    for (int i = 0; i < 10000; i++) begin
      va = $urandom;
      vb = ($urandom_range(0, 7) == 0) ? va : $urandom;
      if ($urandom_range(0, 7) == 0) vb = va ^ (32'h1 << $urandom_range(0, 31));
      v  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      apply(va, vb, v);
      if (v) exp_f = {va < vb, va == vb, va > vb};
      n_checks++;
      if ({out_lt, eq, gt, out_valid} !== {exp_f, v}) begin
        n_fail++;
        $display("FAIL rand_%0d a=%08h b=%08h v=%b: got %b want %b", i, va, vb, v,
                 {out_lt, eq, gt, out_valid}, {exp_f, v});
      end
      if (v) begin
        n_checks++;
        if ($countones({out_lt, eq, gt}) != 1) begin
          n_fail++;
          $display("FAIL rand_onehot_%0d: got %b want exactly one bit set", i,
                   {out_lt, eq, gt});
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    test_reset();
    test_equal();
    test_ordering();
    test_handshake();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
